// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encoding constants for the program loader and the control decoder.
// Contents: major opcodes (OP_*), R-type funct codes (FN_*), the loader request-op enum,
// the loader FSM state enum and an R-type packing helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011100;

  typedef enum logic [3:0] {
    ReqLw   = 4'd0,
    ReqSw   = 4'd1,
    ReqAdd  = 4'd2,
    ReqSub  = 4'd3,
    ReqSlt  = 4'd4,
    ReqMul  = 4'd5,
    ReqAddi = 4'd6,
    ReqBeq  = 4'd7,
    ReqJ    = 4'd8
  } req_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StVerify,
    StDone
  } loader_state_e;

  function automatic logic [31:0] enc_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

endpackage

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: pure combinational request-fields -> 32-bit MIPS word.
// Ports:
//   i_op[3:0]       request op class (req_op_e), values above ReqJ are illegal
//   i_rs/i_rt/i_rd  register fields
//   i_imm[15:0]     I-type immediate
//   i_target[25:0]  J-type target
//   o_word[31:0]    encoded instruction (0 when illegal)
//   o_illegal       op class not encodable
module mips_instr_encoder
  import mips_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (i_op)
      ReqLw:   o_word = {OP_LW, i_rs, i_rt, i_imm};
      ReqSw:   o_word = {OP_SW, i_rs, i_rt, i_imm};
      ReqAdd:  o_word = enc_rtype(i_rs, i_rt, i_rd, FN_ADD);
      ReqSub:  o_word = enc_rtype(i_rs, i_rt, i_rd, FN_SUB);
      ReqSlt:  o_word = enc_rtype(i_rs, i_rt, i_rd, FN_SLT);
      ReqMul:  o_word = enc_rtype(i_rs, i_rt, i_rd, FN_MUL);
      ReqAddi: o_word = {OP_ADDI, i_rs, i_rt, i_imm};
      ReqBeq:  o_word = {OP_BEQ, i_rs, i_rt, i_imm};
      ReqJ:    o_word = {OP_J, i_target};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: encodes instruction requests into MIPS words and writes them
// sequentially into instruction memory, holding the CPU in reset while loading.
// Parameters: BASE_ADDR (byte address of word 0), DEPTH (capacity in words).
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_start                   begin a new load (honoured in idle/done only)
//   i_req_valid/o_req_ready   request handshake
//   i_req_op/rs/rt/rd/imm/target/last   request fields
//   o_imem_we/addr/wdata      instruction-memory write port
//   o_cpu_rst_hold            CPU held in reset while loading
//   o_load_done               level, load finished
//   o_err_illegal/overflow    sticky error flags
//   o_word_count              words written in the current load
// Optional feature: define IMEM_READBACK_EN to add i_imem_rdata / o_err_verify and a
// one-cycle read-back check after every write.
module imem_program_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256,
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [3:0]    i_req_op,
  input  logic [4:0]    i_req_rs,
  input  logic [4:0]    i_req_rt,
  input  logic [4:0]    i_req_rd,
  input  logic [15:0]   i_req_imm,
  input  logic [25:0]   i_req_target,
  input  logic          i_req_last,
  output logic          o_imem_we,
  output logic [31:0]   o_imem_addr,
  output logic [31:0]   o_imem_wdata,
  output logic          o_cpu_rst_hold,
  output logic          o_load_done,
  output logic          o_err_illegal,
  output logic          o_err_overflow,
  output logic [CW-1:0] o_word_count
`ifdef IMEM_READBACK_EN
  ,
  input  logic [31:0]   i_imem_rdata,
  output logic          o_err_verify
`endif
);

  loader_state_e r_state, w_state_d;

  logic [3:0]    r_op;
  logic [4:0]    r_rs, r_rt, r_rd;
  logic [15:0]   r_imm;
  logic [25:0]   r_target;
  logic          r_last;
  logic          r_ovf;  // captured request arrived with memory already full
  logic [CW-1:0] r_word_count;
  logic          r_err_illegal, r_err_overflow;

  logic [31:0]   w_word;
  logic          w_illegal;
  logic          w_accept, w_we, w_restart, w_inc;

  mips_instr_encoder u_encoder (
    .i_op     (r_op),
    .i_rs     (r_rs),
    .i_rt     (r_rt),
    .i_rd     (r_rd),
    .i_imm    (r_imm),
    .i_target (r_target),
    .o_word   (w_word),
    .o_illegal(w_illegal)
  );

  assign w_accept  = (r_state == StLoad) && i_req_valid;
  assign w_restart = ((r_state == StIdle) || (r_state == StDone)) && i_start;

`ifdef IMEM_READBACK_EN
  // Count advances after the check so the verify cycle reads back the same address.
  assign w_inc = (r_state == StVerify);
`else
  assign w_inc = w_we;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_d = StLoad;
      StLoad:  if (i_req_valid) w_state_d = StWrite;
      StWrite: begin
`ifdef IMEM_READBACK_EN
        if (w_we)        w_state_d = StVerify;
        else if (r_last) w_state_d = StDone;
        else             w_state_d = StLoad;
`else
        w_state_d = r_last ? StDone : StLoad;
`endif
      end
`ifdef IMEM_READBACK_EN
      StVerify: w_state_d = r_last ? StDone : StLoad;
`endif
      StDone:  if (i_start) w_state_d = StLoad;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    o_req_ready    = (r_state == StLoad);
    w_we           = (r_state == StWrite) && !w_illegal && !r_ovf;
    o_imem_we      = w_we;
    o_imem_wdata   = w_we ? w_word : 32'h0;
    o_imem_addr    = BASE_ADDR + (32'(r_word_count) << 2);
    o_cpu_rst_hold = (r_state == StLoad) || (r_state == StWrite) || (r_state == StVerify);
    o_load_done    = (r_state == StDone);
  end

  // Request capture, word counter and sticky errors
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op           <= '0;
      r_rs           <= '0;
      r_rt           <= '0;
      r_rd           <= '0;
      r_imm          <= '0;
      r_target       <= '0;
      r_last         <= 1'b0;
      r_ovf          <= 1'b0;
      r_word_count   <= '0;
      r_err_illegal  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_restart) begin
        r_word_count   <= '0;
        r_err_illegal  <= 1'b0;
        r_err_overflow <= 1'b0;
      end
      if (w_accept) begin
        r_op     <= i_req_op;
        r_rs     <= i_req_rs;
        r_rt     <= i_req_rt;
        r_rd     <= i_req_rd;
        r_imm    <= i_req_imm;
        r_target <= i_req_target;
        r_last   <= i_req_last;
        r_ovf    <= (r_word_count == CW'(DEPTH));
        if (r_word_count == CW'(DEPTH)) r_err_overflow <= 1'b1;
      end
      if ((r_state == StWrite) && w_illegal) r_err_illegal <= 1'b1;
      if (w_inc) r_word_count <= r_word_count + 1'b1;
    end
  end

`ifdef IMEM_READBACK_EN
  logic r_err_verify;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_verify <= 1'b0;
    end else if (w_restart) begin
      r_err_verify <= 1'b0;
    end else if ((r_state == StVerify) && (i_imem_rdata != w_word)) begin
      r_err_verify <= 1'b1;
    end
  end

  assign o_err_verify = r_err_verify;
`endif

  assign o_err_illegal  = r_err_illegal;
  assign o_err_overflow = r_err_overflow;
  assign o_word_count   = r_word_count;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: a table of encoding vectors, hand-written
// multi-cycle sequences, and randomized loads checked against an arithmetic encoding model.
// A second DEPTH=2 instance shares all inputs and is checked only for overflow behaviour.
module tb_imem_program_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, req_valid, req_last;
  logic [3:0]  req_op;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [15:0] req_imm;
  logic [25:0] req_target;

  logic        m_ready, m_we, m_hold, m_done, m_eill, m_eovf;
  logic [31:0] m_addr, m_wdata;
  logic [8:0]  m_cnt;
  logic        s_ready, s_we, s_hold, s_done, s_eill, s_eovf;
  logic [31:0] s_addr, s_wdata;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

`ifdef IMEM_READBACK_EN
  logic [31:0] mem [0:255];
  logic [31:0] rdata;
  logic        corrupt = 1'b0;
  logic        m_everify, s_everify;
  logic [7:0]  m_idx;
  assign m_idx = m_addr[9:2] - BASE[9:2];
  assign rdata = mem[m_idx] ^ ((corrupt && m_idx == 8'd1) ? 32'h0000_0001 : 32'h0);
  always @(posedge clk) if (m_we) mem[m_idx] <= m_wdata;
`endif

  imem_program_loader #(.BASE_ADDR(BASE), .DEPTH(256)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_req_valid(req_valid), .o_req_ready(m_ready),
    .i_req_op(req_op), .i_req_rs(req_rs), .i_req_rt(req_rt), .i_req_rd(req_rd),
    .i_req_imm(req_imm), .i_req_target(req_target), .i_req_last(req_last),
    .o_imem_we(m_we), .o_imem_addr(m_addr), .o_imem_wdata(m_wdata), .o_cpu_rst_hold(m_hold),
    .o_load_done(m_done), .o_err_illegal(m_eill), .o_err_overflow(m_eovf),
    .o_word_count(m_cnt)
`ifdef IMEM_READBACK_EN
    , .i_imem_rdata(rdata), .o_err_verify(m_everify)
`endif
  );

  imem_program_loader #(.BASE_ADDR(BASE), .DEPTH(2)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_req_valid(req_valid), .o_req_ready(s_ready),
    .i_req_op(req_op), .i_req_rs(req_rs), .i_req_rt(req_rt), .i_req_rd(req_rd),
    .i_req_imm(req_imm), .i_req_target(req_target), .i_req_last(req_last),
    .o_imem_we(s_we), .o_imem_addr(s_addr), .o_imem_wdata(s_wdata), .o_cpu_rst_hold(s_hold),
    .o_load_done(s_done), .o_err_illegal(s_eill), .o_err_overflow(s_eovf),
    .o_word_count(s_cnt)
`ifdef IMEM_READBACK_EN
    , .i_imem_rdata(rdata), .o_err_verify(s_everify)
`endif
  );

  // Write monitor, sampled on the falling edge
  logic [31:0] wa_q[$], wd_q[$];
  int s_writes = 0;
  always @(negedge clk) begin
    if (m_we) begin
      wa_q.push_back(m_addr);
      wd_q.push_back(m_wdata);
    end
    if (s_we) s_writes++;
  end

  // Reference encoding straight from the instruction-format rules: {illegal, word}
  function automatic logic [32:0] ref_encode(input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] tgt);
    case (op)
      4'd0:    return {1'b0, 6'd35, rs, rt, imm};
      4'd1:    return {1'b0, 6'd43, rs, rt, imm};
      4'd2:    return {1'b0, 6'd0, rs, rt, rd, 5'd0, 6'd32};
      4'd3:    return {1'b0, 6'd0, rs, rt, rd, 5'd0, 6'd34};
      4'd4:    return {1'b0, 6'd0, rs, rt, rd, 5'd0, 6'd42};
      4'd5:    return {1'b0, 6'd0, rs, rt, rd, 5'd0, 6'd28};
      4'd6:    return {1'b0, 6'd8, rs, rt, imm};
      4'd7:    return {1'b0, 6'd4, rs, rt, imm};
      4'd8:    return {1'b0, 6'd2, tgt};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Present one request and wait (bounded) for it to be taken; returns in the cycle after accept.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    bit taken = 0;
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_target = tgt; req_last = last;
    req_valid = 1'b1;
    for (int c = 0; c < 20 && !taken; c++) begin
      @(negedge clk);
      if (m_ready) taken = 1;
    end
    n_cmp++;
    if (!taken) begin
      n_bad++;
      $display("FAIL send_timeout: got ready=0 for 20 cycles, expected ready=1");
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_last = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        wr;
    logic [31:0] word;
  } vec_t;

  vec_t        vt[10];
  logic [32:0] e;
  logic [31:0] exp_a[$], exp_d[$];
  int          nill, base_w, k;
  logic [3:0]  rop;

  initial begin
    vt[0] = '{4'd0, 5'd16, 5'd8, 5'd7, 16'h0004, 26'h3FF_FFFF, 1'b1, 32'h8E08_0004};
    vt[1] = '{4'd2, 5'd8, 5'd9, 5'd10, 16'h1234, 26'h155_5555, 1'b1, 32'h0109_5020};
    vt[2] = '{4'd7, 5'd8, 5'd9, 5'd31, 16'hFFFF, 26'h0, 1'b1, 32'h1109_FFFF};
    vt[3] = '{4'hF, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h1, 1'b0, 32'h0};
    vt[4] = '{4'd1, 5'd1, 5'd2, 5'd3, 16'h0010, 26'h0, 1'b1, 32'hAC22_0010};
    vt[5] = '{4'd3, 5'd3, 5'd4, 5'd5, 16'hFFFF, 26'h0, 1'b1, 32'h0064_2822};
    vt[6] = '{4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_182A};
    vt[7] = '{4'd5, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_181C};
    vt[8] = '{4'd6, 5'd2, 5'd2, 5'd9, 16'h7FFF, 26'h0, 1'b1, 32'h2042_7FFF};
    vt[9] = '{4'd8, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h10, 1'b1, 32'h0800_0010};

    rst = 1'b1; start = 1'b0; req_valid = 1'b0; req_last = 1'b0;
    req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0;

    // Reset state
    cycles(2);
    check("rst_ready", m_ready, 0);
    check("rst_we", m_we, 0);
    check("rst_addr", m_addr, BASE);
    check("rst_wdata", m_wdata, 0);
    check("rst_hold", m_hold, 0);
    check("rst_done", m_done, 0);
    check("rst_errs", {m_eill, m_eovf}, 0);
    check("rst_count", m_cnt, 0);
    rst = 1'b0;
    cycles(1);

    // Single LW with last: write strobe timing, address, data
    start = 1'b1;
    @(negedge clk);
    check("hold_before_start", m_hold, 0);
    @(posedge clk);
    #1 start = 1'b0;
    check("hold_after_start", m_hold, 1);
    check("ready_in_load", m_ready, 1);
    send(4'd0, 5'd16, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1);
    check("lw_we", m_we, 1);
    check("lw_addr", m_addr, BASE);
    check("lw_wdata", m_wdata, 32'h8E08_0004);
    cycles(1);
    check("lw_we_one_cycle", m_we, 0);
    check("lw_done", m_done, 1);
    check("lw_hold_released", m_hold, 0);
    check("lw_count", m_cnt, 1);

    // Table load with an illegal op in the middle and an ignored start
    pulse_start();
    check("restart_count", m_cnt, 0);
    check("restart_addr", m_addr, BASE);
    wa_q.delete(); wd_q.delete();
    for (int i = 0; i < 10; i++) begin
      send(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].imm, vt[i].tgt, i == 9);
      if (i == 2) pulse_start();
    end
    cycles(2);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) begin
        if (k < wd_q.size()) begin
          check($sformatf("tbl_addr[%0d]", i), wa_q[k], BASE + 32'(4 * k));
          check($sformatf("tbl_word[%0d]", i), wd_q[k], vt[i].word);
        end
        k++;
      end
    end
    check("tbl_nwrites", wd_q.size(), k);
    check("tbl_done", m_done, 1);
    check("tbl_hold", m_hold, 0);
    check("tbl_count", m_cnt, 9);
    check("tbl_err_illegal", m_eill, 1);
    check("tbl_err_overflow", m_eovf, 0);

    // Start in DONE clears errors; J with last
    pulse_start();
    check("clr_err_illegal", m_eill, 0);
    check("clr_count", m_cnt, 0);
    wa_q.delete(); wd_q.delete();
    send(4'd8, 5'd3, 5'd4, 5'd5, 16'h9999, 26'h10, 1'b1);
    check("j_wdata", m_wdata, 32'h0800_0010);
    cycles(1);
    check("j_done", m_done, 1);
    check("j_hold", m_hold, 0);
    check("j_count", m_cnt, 1);

    // Overflow on the DEPTH=2 instance
    pulse_start();
    wa_q.delete(); wd_q.delete();
    base_w = s_writes;
    for (int i = 0; i < 3; i++) send(4'd6, 5'd1, 5'd1, 5'd0, 16'(i), 26'h0, i == 2);
    cycles(2);
    check("ovf_small_writes", s_writes - base_w, 2);
    check("ovf_small_err", s_eovf, 1);
    check("ovf_small_done", s_done, 1);
    check("ovf_small_count", s_cnt, 2);
    check("ovf_main_writes", wd_q.size(), 3);
    check("ovf_main_err", m_eovf, 0);

    // Randomized loads against the reference model
    for (int r = 0; r < 4; r++) begin
      pulse_start();
      wa_q.delete(); wd_q.delete(); exp_a.delete(); exp_d.delete();
      nill = 0;
      for (int i = 0; i < 16; i++) begin
        rop = 4'($urandom_range(0, 10));
        req_rs = 5'($urandom); req_rt = 5'($urandom); req_rd = 5'($urandom);
        req_imm = 16'($urandom); req_target = 26'($urandom);
        e = ref_encode(rop, req_rs, req_rt, req_rd, req_imm, req_target);
        if (e[32]) begin
          nill++;
        end else begin
          exp_a.push_back(BASE + 32'(4 * exp_d.size()));
          exp_d.push_back(e[31:0]);
        end
        send(rop, req_rs, req_rt, req_rd, req_imm, req_target, i == 15);
      end
      cycles(2);
      check($sformatf("rnd%0d_nwrites", r), wd_q.size(), exp_d.size());
      for (int i = 0; i < exp_d.size() && i < wd_q.size(); i++) begin
        check($sformatf("rnd%0d_addr[%0d]", r, i), wa_q[i], exp_a[i]);
        check($sformatf("rnd%0d_word[%0d]", r, i), wd_q[i], exp_d[i]);
      end
      check($sformatf("rnd%0d_count", r), m_cnt, exp_d.size());
      check($sformatf("rnd%0d_err_illegal", r), m_eill, nill > 0);
      check($sformatf("rnd%0d_done", r), m_done, 1);
    end

`ifdef IMEM_READBACK_EN
    // Read-back: corrupt only word 1
    pulse_start();
    corrupt = 1'b1;
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'h0AAA, 26'h0, 1'b0);
    cycles(2);
    check("verify_word0_clean", m_everify, 0);
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'h0BBB, 26'h0, 1'b0);
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'h0CCC, 26'h0, 1'b1);
    cycles(2);
    check("verify_word1_bad", m_everify, 1);
    corrupt = 1'b0;
    pulse_start();
    check("verify_cleared", m_everify, 0);
    for (int i = 0; i < 3; i++) send(4'd0, 5'd4, 5'd5, 5'd0, 16'(i), 26'h0, i == 2);
    cycles(2);
    check("verify_clean_load", m_everify, 0);
    check("verify_count", m_cnt, 3);
`endif

    // Asynchronous reset in the middle of a write
    pulse_start();
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    check("abort_we_before", m_we, 1);
    base_w = wd_q.size();
    rst = 1'b1;
    #1;
    check("abort_we", m_we, 0);
    check("abort_wdata", m_wdata, 0);
    check("abort_ready", m_ready, 0);
    check("abort_hold", m_hold, 0);
    check("abort_count", m_cnt, 0);
    check("abort_addr", m_addr, BASE);
    req_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycles(4);
    req_valid = 1'b0;
    check("abort_no_more_writes", wd_q.size(), base_w);
    check("abort_idle_ready", m_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
